// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between fetch and load/store; optional inst starvation guard via ARB_STARVE_GUARD_EN
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] ADDR_MASK = 32'h1FFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_gnt,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);
   typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;
   owner_e rd_owner_q, rd_owner_d;
   logic force_inst;
`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt_q, starve_cnt_d;
   // count consecutive cycles a pending fetch is passed over
   always_comb starve_cnt_d = (inst_req && !inst_gnt) ? starve_cnt_q + 4'd1 : 4'd0;
   // starvation counter register
   always_ff @(posedge clk) starve_cnt_q <= reset ? 4'd0 : starve_cnt_d;
   assign force_inst = starve_cnt_q == 4'(STARVE_LIMIT);
`else
   assign force_inst = 1'b0;
`endif
   // grant, SRAM drive and response routing; everything held low in reset
   always_comb begin
      data_gnt    = !reset && data_req && !(force_inst && inst_req);
      inst_gnt    = !reset && inst_req && !data_gnt;
      sram_en     = inst_gnt || data_gnt;
      sram_addr   = data_gnt ? (data_addr & ADDR_MASK) : inst_gnt ? (inst_addr & ADDR_MASK) : 32'd0;
      sram_wen    = data_gnt ? data_wen : 4'd0;
      sram_wdata  = data_gnt ? data_wdata : 32'd0;
      rd_owner_d  = inst_gnt ? OWN_INST : (data_gnt && data_wen == 4'd0) ? OWN_DATA : OWN_NONE;
      inst_rvalid = !reset && rd_owner_q == OWN_INST;
      data_rvalid = !reset && rd_owner_q == OWN_DATA;
      inst_rdata  = inst_rvalid ? sram_rdata : 32'd0;
      data_rdata  = data_rvalid ? sram_rdata : 32'd0;
   end
   // remember who owns the read returning next cycle
   always_ff @(posedge clk) rd_owner_q <= reset ? OWN_NONE : rd_owner_d;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table, directed corner sequences and randomized checking against a reference model
module tb_sram_port_arbiter;
   localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset, inst_req, data_req;
   logic [31:0] inst_addr, data_addr, data_wdata, sram_rdata;
   logic [3:0] data_wen;
   logic inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
   logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
   logic [3:0] sram_wen;
   int n_cmp = 0, n_bad = 0;
   int resp_q[$];
   int denied = 0;
   logic e_ig, e_dg, e_en, e_irv, e_drv;
   logic [3:0] e_wen;
   logic [31:0] e_addr, e_wdata, e_ird, e_drd;

   always #5 clk = ~clk;

   sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_MASK(32'h1FFFFFFF)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // requesters must hold their request fields while waiting for a grant
   logic p_rst = 1'b1, p_ireq = 1'b0, p_ig = 1'b0, p_dreq = 1'b0, p_dg = 1'b0;
   logic [31:0] p_ia = '0, p_da = '0, p_dwd = '0;
   logic [3:0] p_dw = '0;
   always @(posedge clk) begin
      if (!p_rst && !reset && p_ireq && !p_ig && inst_req)
         assert (inst_addr == p_ia) else $error("illegal inst_addr change while waiting");
      if (!p_rst && !reset && p_dreq && !p_dg && data_req)
         assert (data_addr == p_da && data_wen == p_dw && data_wdata == p_dwd) else $error("illegal data change while waiting");
      p_rst <= reset; p_ireq <= inst_req; p_ig <= inst_gnt; p_dreq <= data_req; p_dg <= data_gnt;
      p_ia <= inst_addr; p_da <= data_addr; p_dw <= data_wen; p_dwd <= data_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: who wins this cycle, and which read (if any) is due back now
   task automatic model_eval();
      bit force_i;
      int owner;
      force_i = GUARD && denied >= LIMIT;
      e_dg    = !reset && data_req && !(force_i && inst_req);
      e_ig    = !reset && inst_req && !e_dg;
      e_en    = e_ig || e_dg;
      e_addr  = e_dg ? (data_addr & 32'h1FFFFFFF) : e_ig ? (inst_addr & 32'h1FFFFFFF) : 32'd0;
      e_wen   = e_dg ? data_wen : 4'd0;
      e_wdata = e_dg ? data_wdata : 32'd0;
      owner   = (!reset && resp_q.size() > 0) ? resp_q[0] : 0;
      e_irv   = owner == 1;
      e_drv   = owner == 2;
      e_ird   = e_irv ? sram_rdata : 32'd0;
      e_drd   = e_drv ? sram_rdata : 32'd0;
   endtask

   task automatic model_update();
      if (reset) begin
         resp_q.delete();
         denied = 0;
      end else begin
         if (resp_q.size() > 0) void'(resp_q.pop_front());
         if (e_ig) resp_q.push_back(1);
         else if (e_dg && data_wen == 4'd0) resp_q.push_back(2);
         denied = (inst_req && !e_ig) ? denied + 1 : 0;
      end
   endtask

   task automatic check_model();
      chk("rnd_inst_gnt", inst_gnt, e_ig);
      chk("rnd_data_gnt", data_gnt, e_dg);
      chk("rnd_sram_en", sram_en, e_en);
      chk("rnd_sram_wen", sram_wen, e_wen);
      chk("rnd_sram_addr", sram_addr, e_addr);
      chk("rnd_sram_wdata", sram_wdata, e_wdata);
      chk("rnd_inst_rvalid", inst_rvalid, e_irv);
      chk("rnd_inst_rdata", inst_rdata, e_ird);
      chk("rnd_data_rvalid", data_rvalid, e_drv);
      chk("rnd_data_rdata", data_rdata, e_drd);
   endtask

   task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [31:0] srd);
      reset = r; inst_req = ir; inst_addr = ia; data_req = dr;
      data_wen = dw; data_addr = da; data_wdata = dwd; sram_rdata = srd;
      @(negedge clk);
      model_eval();
   endtask

   task automatic end_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   typedef struct {
      logic r, ir; logic [31:0] ia; logic dr; logic [3:0] dw; logic [31:0] da, dwd, srd;
      logic ig, dg, en; logic [3:0] wen; logic [31:0] addr, wdata;
      logic irv; logic [31:0] ird; logic drv; logic [31:0] drd;
   } vec_t;
   vec_t tbl[7];

   initial begin
      logic r, ir, dr, hold_i, hold_d, ex_ig;
      logic [31:0] ia, da, dwd;
      logic [3:0] dw;
      tbl[0] = '{1'b1, 1'b1, 32'hBFC00000, 1'b1, '0, 32'h80000010, '0, 32'hAAAAAAAA,
                 '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
      tbl[1] = '{'0, 1'b1, 32'hBFC00000, '0, '0, '0, '0, '0,
                 1'b1, '0, 1'b1, '0, 32'h1FC00000, '0, '0, '0, '0, '0};
      tbl[2] = '{'0, '0, '0, '0, '0, '0, '0, 32'h24080001,
                 '0, '0, '0, '0, '0, '0, 1'b1, 32'h24080001, '0, '0};
      tbl[3] = '{'0, 1'b1, 32'hBFC00100, 1'b1, '0, 32'h80000010, '0, '0,
                 '0, 1'b1, 1'b1, '0, 32'h00000010, '0, '0, '0, '0, '0};
      tbl[4] = '{'0, 1'b1, 32'hBFC00100, '0, '0, '0, '0, 32'hDEADBEEF,
                 1'b1, '0, 1'b1, '0, 32'h1FC00100, '0, '0, '0, 1'b1, 32'hDEADBEEF};
      tbl[5] = '{'0, '0, '0, 1'b1, 4'b0011, 32'h80000004, 32'h0000BEEF, 32'h11111111,
                 '0, 1'b1, 1'b1, 4'b0011, 32'h00000004, 32'h0000BEEF, 1'b1, 32'h11111111, '0, '0};
      tbl[6] = '{'0, '0, '0, '0, '0, '0, '0, 32'h22222222,
                 '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd, tbl[i].srd);
         chk($sformatf("v%0d_inst_gnt", i), inst_gnt, tbl[i].ig);
         chk($sformatf("v%0d_data_gnt", i), data_gnt, tbl[i].dg);
         chk($sformatf("v%0d_sram_en", i), sram_en, tbl[i].en);
         chk($sformatf("v%0d_sram_wen", i), sram_wen, tbl[i].wen);
         chk($sformatf("v%0d_sram_addr", i), sram_addr, tbl[i].addr);
         chk($sformatf("v%0d_sram_wdata", i), sram_wdata, tbl[i].wdata);
         chk($sformatf("v%0d_inst_rvalid", i), inst_rvalid, tbl[i].irv);
         chk($sformatf("v%0d_inst_rdata", i), inst_rdata, tbl[i].ird);
         chk($sformatf("v%0d_data_rvalid", i), data_rvalid, tbl[i].drv);
         chk($sformatf("v%0d_data_rdata", i), data_rdata, tbl[i].drd);
         end_cycle();
      end
      // both requesters held for ten cycles: starvation guard behaviour
      for (int k = 1; k <= 10; k++) begin
         drive(1'b0, 1'b1, 32'h00000040, 1'b1, 4'd0, 32'h00000020, 32'd0, 32'd0);
         ex_ig = GUARD && (k == 5 || k == 10);
         chk($sformatf("starve_c%0d_inst_gnt", k), inst_gnt, ex_ig);
         chk($sformatf("starve_c%0d_data_gnt", k), data_gnt, !ex_ig);
         end_cycle();
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      end_cycle();
      // inst read granted, then reset in the response cycle drops it
      drive(1'b0, 1'b1, 32'h00000100, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      chk("rst_pre_inst_gnt", inst_gnt, 1'b1);
      end_cycle();
      drive(1'b1, 1'b1, 32'h00000100, 1'b1, 4'd0, 32'h00000200, 32'd0, 32'h55555555);
      chk("rst_inst_rvalid", inst_rvalid, 1'b0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_inst_gnt", inst_gnt, 1'b0);
      chk("rst_data_gnt", data_gnt, 1'b0);
      chk("rst_sram_en", sram_en, 1'b0);
      chk("rst_sram_addr", sram_addr, 32'd0);
      end_cycle();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h66666666);
      chk("post_rst_inst_rvalid", inst_rvalid, 1'b0);
      chk("post_rst_data_rvalid", data_rvalid, 1'b0);
      end_cycle();
      // alternating back-to-back reads inst/data/inst/data
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, k < 4 && k % 2 == 0, 32'(k * 4), k < 4 && k % 2 == 1, 4'd0, 32'(k * 4), 32'd0, 32'hC0DE0000 + 32'(k));
         if (k < 4) begin
            chk($sformatf("alt%0d_inst_gnt", k), inst_gnt, k % 2 == 0);
            chk($sformatf("alt%0d_data_gnt", k), data_gnt, k % 2 == 1);
            chk($sformatf("alt%0d_sram_addr", k), sram_addr, 32'(k * 4));
         end
         if (k > 0) begin
            chk($sformatf("alt%0d_inst_rvalid", k), inst_rvalid, (k - 1) % 2 == 0);
            chk($sformatf("alt%0d_data_rvalid", k), data_rvalid, (k - 1) % 2 == 1);
            chk($sformatf("alt%0d_inst_rdata", k), inst_rdata, (k - 1) % 2 == 0 ? 32'hC0DE0000 + 32'(k) : 32'd0);
            chk($sformatf("alt%0d_data_rdata", k), data_rdata, (k - 1) % 2 == 1 ? 32'hC0DE0000 + 32'(k) : 32'd0);
         end
         end_cycle();
      end
      // randomized traffic against the reference model
      hold_i = 1'b0; hold_d = 1'b0;
      ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dwd = '0; dw = '0;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 49) == 0;
         if (!hold_i) begin ir = $urandom_range(0, 2) != 0; ia = $urandom; end
         else if ($urandom_range(0, 4) == 0) ir = 1'b0;
         if (!hold_d) begin
            dr = $urandom_range(0, 1) == 1; da = $urandom; dwd = $urandom;
            dw = $urandom_range(0, 1) == 1 ? 4'd0 : 4'($urandom);
         end else if ($urandom_range(0, 4) == 0) dr = 1'b0;
         drive(r, ir, ia, dr, dw, da, dwd, $urandom);
         check_model();
         hold_i = ir && !e_ig && !r;
         hold_d = dr && !e_dg && !r;
         end_cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
